// File: rtl/exc_pipe_ctrl_if.sv
// Pipeline <-> exception controller bundle: MEM-stage requests, hazard flags,
// and the clear/stall/redirect/CP0 outputs. ie_out exists only with EXC_CTRL_INT_EN.
interface exc_pipe_ctrl_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        int_req;
  logic        eret_req;
  logic        load_use;
  logic        md_busy;
  logic        ifid_clr;
  logic        idex_clr;
  logic        exmem_clr;
  logic        memwb_clr;
  logic        pc_stall;
  logic        ifid_stall;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [4:0]  cause_code;
  logic        cause_bd;
  logic        exl;
  logic        busy;
`ifdef EXC_CTRL_INT_EN
  logic        ie_out;
`endif

  // Pipeline side.
  modport master (
    output exc_req, exc_code, exc_pc, exc_bd, int_req, eret_req, load_use, md_busy,
    input  ifid_clr, idex_clr, exmem_clr, memwb_clr, pc_stall, ifid_stall,
           pc_redirect, redirect_pc, epc, cause_code, cause_bd, exl, busy
`ifdef EXC_CTRL_INT_EN
    , input ie_out
`endif
  );

  // Controller side.
  modport slave (
    input  exc_req, exc_code, exc_pc, exc_bd, int_req, eret_req, load_use, md_busy,
    output ifid_clr, idex_clr, exmem_clr, memwb_clr, pc_stall, ifid_stall,
           pc_redirect, redirect_pc, epc, cause_code, cause_bd, exl, busy
`ifdef EXC_CTRL_INT_EN
    , output ie_out
`endif
  );
endinterface

// File: rtl/exc_pipe_ctrl.sv
// Exception/ERET sequencer and hazard-stall controller for the 5-stage pipeline.
// Optional macro EXC_CTRL_INT_EN enables interrupt acceptance gated by an ie bit.
module exc_pipe_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          CNT_W        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  exc_pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      epc_reg, epc_next;
  logic [4:0]       cause_code_reg, cause_code_next;
  logic             cause_bd_reg, cause_bd_next;
  logic             exl_reg, exl_next;
  logic [31:0]      target_reg, target_next;
  logic [31:0]      redirect_pc_reg, redirect_pc_next;
  logic             ie_reg, ie_next;

  logic idle, exc_acc, int_acc, eret_acc, accept, hazard;

  assign idle    = (state_reg == IDLE);
  assign exc_acc = idle && bus.exc_req && !exl_reg;
`ifdef EXC_CTRL_INT_EN
  assign int_acc = idle && bus.int_req && ie_reg && !exl_reg && !exc_acc;
`else
  logic int_req_unused;
  assign int_req_unused = bus.int_req;
  assign int_acc        = 1'b0;
`endif
  assign eret_acc = idle && bus.eret_req && exl_reg && !exc_acc && !int_acc;
  assign accept   = exc_acc || int_acc || eret_acc;
  // An accepted request takes precedence over a bubble in the same cycle.
  assign hazard   = idle && !accept && (bus.load_use || bus.md_busy);

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    epc_next         = epc_reg;
    cause_code_next  = cause_code_reg;
    cause_bd_next    = cause_bd_reg;
    exl_next         = exl_reg;
    target_next      = target_reg;
    redirect_pc_next = redirect_pc_reg;
    ie_next          = ie_reg;
    case (state_reg)
      IDLE: begin
        if (exc_acc || int_acc) begin
          epc_next        = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          cause_code_next = exc_acc ? bus.exc_code : 5'd0;
          cause_bd_next   = bus.exc_bd;
          exl_next        = 1'b1;
          target_next     = HANDLER_ADDR;
          cnt_next        = '0;
          state_next      = FLUSH;
          if (int_acc) ie_next = 1'b0;
        end else if (eret_acc) begin
          exl_next    = 1'b0;
          ie_next     = 1'b1;
          target_next = epc_reg;
          cnt_next    = '0;
          state_next  = FLUSH;
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next       = REDIRECT;
          // Published only on entry to REDIRECT so the output keeps the old target until then.
          redirect_pc_next = target_reg;
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      epc_reg         <= '0;
      cause_code_reg  <= '0;
      cause_bd_reg    <= 1'b0;
      exl_reg         <= 1'b0;
      target_reg      <= HANDLER_ADDR;
      redirect_pc_reg <= HANDLER_ADDR;
      ie_reg          <= 1'b1;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      epc_reg         <= epc_next;
      cause_code_reg  <= cause_code_next;
      cause_bd_reg    <= cause_bd_next;
      exl_reg         <= exl_next;
      target_reg      <= target_next;
      redirect_pc_reg <= redirect_pc_next;
      ie_reg          <= ie_next;
    end
  end

  assign bus.ifid_clr    = (state_reg == FLUSH) || (state_reg == REDIRECT);
  assign bus.idex_clr    = (state_reg == FLUSH) || hazard;
  assign bus.exmem_clr   = (state_reg == FLUSH);
  assign bus.memwb_clr   = (state_reg == FLUSH);
  assign bus.pc_stall    = (state_reg == FLUSH) || hazard;
  assign bus.ifid_stall  = hazard;
  assign bus.pc_redirect = (state_reg == REDIRECT);
  assign bus.redirect_pc = redirect_pc_reg;
  assign bus.epc         = epc_reg;
  assign bus.cause_code  = cause_code_reg;
  assign bus.cause_bd    = cause_bd_reg;
  assign bus.exl         = exl_reg;
  assign bus.busy        = !idle;
`ifdef EXC_CTRL_INT_EN
  assign bus.ie_out      = ie_reg;
`else
  logic ie_unused;
  assign ie_unused = ie_reg ^ ie_next;
`endif
endmodule

// File: doc/exc_pipe_ctrl.md
Name: exc_pipe_ctrl

Overview:
- Exception/ERET sequencer and hazard-stall controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Accepts exception, interrupt and ERET requests from the MEM stage and captures EPC/cause/BD.
- Runs a multi-cycle flush of all four pipeline registers, then redirects the PC to the handler or to EPC.
- In normal operation, generates load-use and mult/div bubbles.

Parameters:
- FLUSH_CYCLES, 1, number of cycles the four clear lines are held (legal range 1..15).
- HANDLER_ADDR, 32'h0000_4180, exception handler entry PC.
- CNT_W, 4, flush counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exc_req  in  1  MEM-stage instruction raised an exception.
- exc_code  in  5  ExcCode of the MEM-stage exception.
- exc_pc  in  32  PC of the MEM-stage instruction.
- exc_bd  in  1  MEM-stage instruction is in a branch delay slot.
- int_req  in  1  external interrupt pending (see Optional Feature).
- eret_req  in  1  ERET in MEM stage.
- load_use  in  1  ID needs the result of a load currently in EX.
- md_busy  in  1  mult/div unit busy while ID reads HI/LO or issues mult/div.
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clears of the pipeline registers.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- pc_redirect  out  1  load redirect_pc into PC.
- redirect_pc  out  32  redirect target.
- epc  out  32  captured EPC.
- cause_code  out  5  captured ExcCode.
- cause_bd  out  1  captured BD flag.
- exl  out  1  exception level; 1 while inside the handler.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, counter=0, epc=0, cause_code=0, cause_bd=0, exl=0.
  - All clr, stall and redirect outputs are 0. redirect_pc=HANDLER_ADDR.
- States: IDLE, FLUSH, REDIRECT.
  - All clr and redirect outputs are Moore-decoded from state.
  - Stall outputs are combinational, and only in IDLE.
- IDLE, request acceptance at a clock edge, priority exc_req > int_req > eret_req:
  - Exception: accepted when exc_req=1 and exl=0.
    - epc <= exc_bd ? exc_pc-4 : exc_pc (32-bit modular subtract; wraps at 0).
    - cause_code <= exc_code, cause_bd <= exc_bd, exl <= 1.
    - target <= HANDLER_ADDR. Next state FLUSH, counter <= 0.
  - Interrupt: same as exception, with cause_code <= 0.
  - ERET: accepted when eret_req=1 and exl=1.
    - exl <= 0, target <= epc. Next state FLUSH.
  - exc_req with exl=1 is ignored (no nesting). eret_req with exl=0 is ignored.
- IDLE stall generation, only when no request is being accepted that cycle:
  - If load_use=1 or md_busy=1: pc_stall=1, ifid_stall=1, idex_clr=1 (one bubble per cycle).
  - Otherwise all 0.
  - An accepted request suppresses stalls in that cycle.
- FLUSH:
  - ifid_clr=idex_clr=exmem_clr=memwb_clr=1, pc_stall=1.
  - Counter increments each cycle. When counter==FLUSH_CYCLES-1, next state is REDIRECT.
  - All request and hazard inputs are ignored.
- REDIRECT, exactly one cycle:
  - pc_redirect=1, redirect_pc=target, ifid_clr=1.
  - Next state IDLE.
- Latency:
  - Request sampled at edge N.
  - FLUSH occupies cycles N+1 .. N+FLUSH_CYCLES.
  - REDIRECT occupies cycle N+FLUSH_CYCLES+1.
  - IDLE resumes at the next edge.
- Reset mid-sequence: returns immediately to IDLE with all outputs at reset values. No redirect is issued.
- redirect_pc holds its last target outside REDIRECT.

Optional Feature:
- Macro EXC_CTRL_INT_EN.
- Defined:
  - Adds internal ie bit, reset 1.
  - int_req is accepted only when ie=1 and exl=0.
  - Accepting an interrupt clears ie. ERET sets ie.
  - Adds output ie_out (1 bit).
- Undefined:
  - int_req is ignored. No ie bit, no ie_out port.
  - Exception and ERET behaviour is unchanged.

Test Plan:
- Basic exception (FLUSH_CYCLES=1): exc_req=1, exc_pc=0x3008, exc_bd=0, exc_code=12 -> next cycle all four clr=1; following cycle pc_redirect=1, redirect_pc=0x4180; epc=0x3008, cause_code=12, exl=1.
- Delay-slot exception: exc_pc=0x3010, exc_bd=1 -> epc=0x300C, cause_bd=1.
- ERET round-trip: after the exception above, eret_req=1 -> clears for 1 cycle, then redirect_pc=0x3008, exl=0. A second eret_req with exl=0 produces no activity.
- Priority and nesting:
  - exc_req, int_req and eret_req together in IDLE -> exception accepted, cause_code=exc_code.
  - exc_req while exl=1 -> ignored, busy stays 0.
- Hazards:
  - load_use=1 for 2 cycles -> pc_stall=ifid_stall=idex_clr=1 for exactly those 2 cycles.
  - load_use=1 with an accepted exc_req in the same cycle -> no stall, FLUSH entered.
- Long flush and reset: FLUSH_CYCLES=3 -> clears held 3 cycles, then redirect. rst_n=0 during the 2nd flush cycle -> outputs zero immediately, state IDLE, no pc_redirect.
